// File: rtl/bias_requant_int8.sv
// Int8 requantisation stage: adds per-lane bias read from the bias SRAM, scales,
// round-shifts, optionally applies ReLU and saturates each of eight lanes to int8.
module bias_requant_int8 #(
  parameter int unsigned ADDR_BIT = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                psum_valid,
  output logic                psum_ready,
  input  logic [7:0][31:0]    psum_data,
  input  logic [ADDR_BIT-1:0] psum_bias_addr,
  input  logic [15:0]         cfg_scale,
  input  logic [4:0]          cfg_shift,
  input  logic                cfg_relu,
  output logic [ADDR_BIT-1:0] bias_addr,
  output logic                bias_en,
  input  logic [7:0][31:0]    bias_do,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [7:0][7:0]     out_data,
  output logic                idle,
  output logic                addr_err
);

  // Highest lane-0 address whose eight bias words all fit in the SRAM.
  localparam logic [ADDR_BIT-1:0] MaxBase = ADDR_BIT'(2 ** ADDR_BIT - 8);

  logic                s1_v_q, s1_v_d;
  logic [7:0][31:0]    s1_psum_q, s1_psum_d;
  logic [15:0]         s1_scale_q, s1_scale_d;
  logic [4:0]          s1_shift_q, s1_shift_d;
  logic                s1_relu_q, s1_relu_d;

  logic                s2_v_q, s2_v_d;
  logic [7:0][32:0]    s2_sum_q, s2_sum_d;
  logic [15:0]         s2_scale_q, s2_scale_d;
  logic [4:0]          s2_shift_q, s2_shift_d;
  logic                s2_relu_q, s2_relu_d;

  logic                s3_v_q, s3_v_d;
  logic [7:0][49:0]    s3_prod_q, s3_prod_d;
  logic [4:0]          s3_shift_q, s3_shift_d;
  logic                s3_relu_q, s3_relu_d;

  logic                out_valid_q, out_valid_d;
  logic [7:0][7:0]     out_data_q, out_data_d;
  logic                bias_en_q, bias_en_d;
  logic [ADDR_BIT-1:0] bias_addr_q, bias_addr_d;
  logic                addr_err_q, addr_err_d;

  logic adv, accept;

  function automatic logic [7:0] requant(input logic [49:0] prod, input logic [4:0] shift,
                                         input logic relu);
    logic signed [50:0] wide;
    logic signed [50:0] r;
    wide = 51'($signed(prod));
    if (shift == 5'd0) begin
      r = wide;
    end else begin
      r = (wide + (51'sd1 <<< (shift - 5'd1))) >>> shift;
    end
    if (relu && (r < 51'sd0)) begin
      r = 51'sd0;
    end
    if (r > 51'sd127) begin
      requant = 8'h7f;
    end else if (r < -51'sd128) begin
      requant = 8'h80;
    end else begin
      requant = r[7:0];
    end
  endfunction

  always_comb begin
    adv    = !out_valid_q || out_ready;
    accept = psum_valid && adv;

    s1_v_d      = s1_v_q;
    s1_psum_d   = s1_psum_q;
    s1_scale_d  = s1_scale_q;
    s1_shift_d  = s1_shift_q;
    s1_relu_d   = s1_relu_q;
    s2_v_d      = s2_v_q;
    s2_sum_d    = s2_sum_q;
    s2_scale_d  = s2_scale_q;
    s2_shift_d  = s2_shift_q;
    s2_relu_d   = s2_relu_q;
    s3_v_d      = s3_v_q;
    s3_prod_d   = s3_prod_q;
    s3_shift_d  = s3_shift_q;
    s3_relu_d   = s3_relu_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    // The whole pipe moves in lockstep; bias_do stays aligned with S1 because the
    // SRAM only refreshes DO after an accept.
    if (adv) begin
      s1_v_d = psum_valid;
      if (accept) begin
        s1_psum_d  = psum_data;
        s1_scale_d = cfg_scale;
        s1_shift_d = cfg_shift;
        s1_relu_d  = cfg_relu;
      end

      s2_v_d     = s1_v_q;
      s2_scale_d = s1_scale_q;
      s2_shift_d = s1_shift_q;
      s2_relu_d  = s1_relu_q;
      for (int i = 0; i < 8; i++) begin
        s2_sum_d[i] = 33'($signed(s1_psum_q[i])) + 33'($signed(bias_do[i]));
      end

      s3_v_d     = s2_v_q;
      s3_shift_d = s2_shift_q;
      s3_relu_d  = s2_relu_q;
      for (int i = 0; i < 8; i++) begin
        s3_prod_d[i] = 50'($signed(s2_sum_q[i])) * 50'($signed({1'b0, s2_scale_q}));
      end

      out_valid_d = s3_v_q;
      for (int i = 0; i < 8; i++) begin
        out_data_d[i] = requant(s3_prod_q[i], s3_shift_q, s3_relu_q);
      end
    end

    bias_en_d   = accept;
    bias_addr_d = accept ? psum_bias_addr : bias_addr_q;
    addr_err_d  = addr_err_q || (accept && (psum_bias_addr > MaxBase));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q      <= 1'b0;
      s1_psum_q   <= '0;
      s1_scale_q  <= '0;
      s1_shift_q  <= '0;
      s1_relu_q   <= 1'b0;
      s2_v_q      <= 1'b0;
      s2_sum_q    <= '0;
      s2_scale_q  <= '0;
      s2_shift_q  <= '0;
      s2_relu_q   <= 1'b0;
      s3_v_q      <= 1'b0;
      s3_prod_q   <= '0;
      s3_shift_q  <= '0;
      s3_relu_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      bias_en_q   <= 1'b0;
      bias_addr_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_psum_q   <= s1_psum_d;
      s1_scale_q  <= s1_scale_d;
      s1_shift_q  <= s1_shift_d;
      s1_relu_q   <= s1_relu_d;
      s2_v_q      <= s2_v_d;
      s2_sum_q    <= s2_sum_d;
      s2_scale_q  <= s2_scale_d;
      s2_shift_q  <= s2_shift_d;
      s2_relu_q   <= s2_relu_d;
      s3_v_q      <= s3_v_d;
      s3_prod_q   <= s3_prod_d;
      s3_shift_q  <= s3_shift_d;
      s3_relu_q   <= s3_relu_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      bias_en_q   <= bias_en_d;
      bias_addr_q <= bias_addr_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign psum_ready = adv;
  assign bias_en    = bias_en_q;
  assign bias_addr  = bias_addr_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign addr_err   = addr_err_q;
  assign idle       = !(s1_v_q || s2_v_q || s3_v_q || out_valid_q);

endmodule

// File: tb/tb_bias_requant_int8.sv
// Bench for bias_requant_int8: directed vector table, random streams under
// backpressure against an arithmetic reference, addr_err and mid-run reset.
module tb_bias_requant_int8;

  localparam int unsigned AddrBit = 7;
  localparam int unsigned Words   = 1 << AddrBit;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               psum_valid = 1'b0;
  logic               psum_ready;
  logic [7:0][31:0]   psum_data = '0;
  logic [AddrBit-1:0] psum_bias_addr = '0;
  logic [15:0]        cfg_scale = '0;
  logic [4:0]         cfg_shift = '0;
  logic               cfg_relu = 1'b0;
  logic [AddrBit-1:0] bias_addr;
  logic               bias_en;
  logic [7:0][31:0]   bias_do = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [7:0][7:0]    out_data;
  logic               idle;
  logic               addr_err;

  bias_requant_int8 #(.ADDR_BIT(AddrBit)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .psum_valid     (psum_valid),
    .psum_ready     (psum_ready),
    .psum_data      (psum_data),
    .psum_bias_addr (psum_bias_addr),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_relu       (cfg_relu),
    .bias_addr      (bias_addr),
    .bias_en        (bias_en),
    .bias_do        (bias_do),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .idle           (idle),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  // Bias SRAM model: DO refreshed on negedge while EN is high.
  logic [31:0] mem [Words];
  always @(negedge clk) begin
    if (bias_en) begin
      for (int i = 0; i < 8; i++) bias_do[i] <= mem[(int'(bias_addr) + i) % Words];
    end
  end

  typedef struct {
    logic [7:0][31:0]   psum;
    logic [AddrBit-1:0] addr;
    logic [15:0]        scale;
    logic [4:0]         shift;
    logic               relu;
    logic [7:0][7:0]    exp;
  } vec_t;

  typedef struct {
    logic            chk;
    logic [7:0][7:0] d;
  } sb_t;

  sb_t  exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_rx = 0;
  int   n_bias_en = 0;
  vec_t tbl[12];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Reference: plain integer arithmetic with floor division for the rounding shift.
  function automatic logic [7:0] ref_lane(longint psum, longint bias, longint scale, int shift,
                                          bit relu);
    longint prod, num, d, r;
    prod = (psum + bias) * scale;
    if (shift == 0) begin
      r = prod;
    end else begin
      d   = longint'(1) << shift;
      num = prod + d / 2;
      r   = num / d;
      if ((num % d != 0) && (num < 0)) r = r - 1;
    end
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r[7:0];
  endfunction

  function automatic logic [7:0][7:0] ref_beat(logic [7:0][31:0] psum, logic [AddrBit-1:0] addr,
                                               logic [15:0] scale, logic [4:0] shift,
                                               logic relu);
    logic [7:0][7:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i] = ref_lane(longint'($signed(psum[i])),
                        longint'($signed(mem[(int'(addr) + i) % Words])),
                        longint'(scale), int'(shift), relu);
    end
    return res;
  endfunction

  // Monitor/scoreboard: sampled at negedge, between the edges that move data.
  logic            prev_stall = 1'b0;
  logic [7:0][7:0] prev_data = '0;
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (bias_en) n_bias_en++;
        check("psum_ready", 64'(psum_ready), 64'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", out_data, prev_data);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        if (out_valid && out_ready) begin
          check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.chk) check("stream_data", out_data, e.d);
          end
          n_rx++;
        end
        if (psum_valid && psum_ready) begin
          e.chk = (int'(psum_bias_addr) <= int'(Words) - 8);
          e.d   = ref_beat(psum_data, psum_bias_addr, cfg_scale, cfg_shift, cfg_relu);
          exp_q.push_back(e);
        end
      end
    end
  end

  task automatic rand_beat();
    for (int i = 0; i < 8; i++) begin
      psum_data[i] = $urandom_range(1) ? $urandom() : 32'($urandom_range(8191)) - 32'd4096;
    end
    psum_bias_addr = AddrBit'($urandom_range(40, Words - 8));
    cfg_scale      = $urandom_range(1) ? 16'($urandom_range(65535)) : 16'($urandom_range(8));
    cfg_shift      = 5'($urandom_range(31));
    cfg_relu       = 1'($urandom_range(1));
    psum_valid     = 1'b1;
  endtask

  // pattern=1: out_ready cycles 1,0,0,1 with back-to-back beats; else random both sides.
  task automatic run_stream(int n, bit pattern);
    int  sent = 0;
    int  cyc = 0;
    int  rx0 = n_rx;
    bit  acc;
    while ((sent < n || n_rx - rx0 < n) && cyc < 3000) begin
      out_ready = pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ($urandom_range(3) != 0);
      if (sent < n && !psum_valid && (pattern || $urandom_range(3) != 0)) rand_beat();
      @(negedge clk);
      acc = psum_valid && psum_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        psum_valid = 1'b0;
      end
      cyc++;
    end
    check("stream_count", 64'(n_rx - rx0), 64'(n));
    out_ready = 1'b1;
  endtask

  task automatic send_one(logic [31:0] p, logic [AddrBit-1:0] a);
    int waitc = 0;
    psum_data      = {8{p}};
    psum_bias_addr = a;
    cfg_scale      = 16'd1;
    cfg_shift      = 5'd0;
    cfg_relu       = 1'b0;
    psum_valid     = 1'b1;
    @(negedge clk);
    while (!psum_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check("send_accept", 64'(psum_ready), 64'd1);
    @(posedge clk);
    #1;
    psum_valid = 1'b0;
  endtask

  initial begin
    int lat;
    for (int i = 0; i < int'(Words); i++) begin
      if (i < 16)      mem[i] = 32'd0;
      else if (i < 24) mem[i] = 32'(i - 16);
      else if (i < 32) mem[i] = 32'd24;
      else if (i < 40) mem[i] = 32'h8000_0000;
      else             mem[i] = $urandom_range(1) ? $urandom() : 32'($urandom_range(8191)) - 32'd4096;
    end

    tbl[0]  = '{{8{32'd12}},         7'd0,  16'd1,     5'd3,  1'b0, {8{8'h02}}};
    tbl[1]  = '{{8{32'hFFFF_FFF4}},  7'd0,  16'd1,     5'd3,  1'b0, {8{8'hff}}};
    tbl[2]  = '{{8{32'hFFFF_FFF4}},  7'd0,  16'd1,     5'd3,  1'b1, {8{8'h00}}};
    tbl[3]  = '{{8{32'd1000}},       7'd24, 16'd1,     5'd3,  1'b0, {8{8'h7f}}};
    tbl[4]  = '{{8{32'h8000_0000}},  7'd32, 16'd65535, 5'd0,  1'b0, {8{8'h80}}};
    tbl[5]  = '{{8{32'd0}},          7'd16, 16'd4,     5'd2,  1'b0,
                {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}};
    tbl[6]  = '{{8{32'd8}},          7'd0,  16'd1,     5'd4,  1'b0, {8{8'h01}}};
    tbl[7]  = '{{8{32'hFFFF_FFF8}},  7'd0,  16'd1,     5'd4,  1'b0, {8{8'h00}}};
    tbl[8]  = '{{8{32'd7}},          7'd0,  16'd65535, 5'd31, 1'b0, {8{8'h00}}};
    tbl[9]  = '{{8{32'h8000_0000}},  7'd32, 16'd65535, 5'd0,  1'b1, {8{8'h00}}};
    tbl[10] = '{{8{32'd100}},        7'd24, 16'd3,     5'd2,  1'b0, {8{8'h5d}}};
    tbl[11] = '{{8{32'hFFFF_FF38}},  7'd0,  16'd1,     5'd1,  1'b0, {8{8'h9c}}};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_bias_en", 64'(bias_en), 64'd0);
    check("rst_bias_addr", 64'(bias_addr), 64'd0);
    check("rst_addr_err", 64'(addr_err), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 64'(psum_ready), 64'd1);

    // Directed vectors, one beat at a time
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      psum_data      = tbl[t].psum;
      psum_bias_addr = tbl[t].addr;
      cfg_scale      = tbl[t].scale;
      cfg_shift      = tbl[t].shift;
      cfg_relu       = tbl[t].relu;
      psum_valid     = 1'b1;
      @(posedge clk);
      #1;
      psum_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
        @(negedge clk);
        if (out_valid) break;
        lat++;
      end
      check($sformatf("vec%0d_latency", t), 64'(lat), 64'd3);
      check($sformatf("vec%0d_data", t), out_data, tbl[t].exp);
      @(negedge clk);
      check($sformatf("vec%0d_idle", t), 64'(idle), 64'd1);
    end

    // Backpressure: 10 back-to-back beats, out_ready 1,0,0,1,...
    @(posedge clk);
    #1;
    n_bias_en = 0;
    run_stream(10, 1'b1);
    check("bias_en_pulses", 64'(n_bias_en), 64'd10);

    // Random traffic on both sides
    run_stream(150, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("addr_err_clear", 64'(addr_err), 64'd0);

    // Highest legal base then first illegal base
    send_one(32'd5, AddrBit'(Words - 8));
    repeat (4) @(posedge clk);
    #1;
    check("addr_err_edge_ok", 64'(addr_err), 64'd0);
    send_one(32'd5, AddrBit'(Words - 7));
    @(negedge clk);
    check("addr_err_set", 64'(addr_err), 64'd1);
    repeat (5) @(negedge clk);
    check("addr_err_sticky", 64'(addr_err), 64'd1);

    // Fill the pipe under stall, then reset mid-flight
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      psum_data      = {8{32'd40}};
      psum_bias_addr = 7'd0;
      cfg_scale      = 16'd1;
      cfg_shift      = 5'd0;
      cfg_relu       = 1'b0;
      psum_valid     = 1'b1;
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    psum_valid = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_addr_err", 64'(addr_err), 64'd0);
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_bias_en", 64'(bias_en), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_stale_beat", 64'(out_valid), 64'd0);
    end
    check("final_idle", 64'(idle), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, expected $finish");
    $fatal(1);
  end

endmodule
